// File: rtl/cache_top.sv
// Set-associative L1 cache model for trace-driven policy evaluation.
// One access per clock on cache_addr (bit 0: 1 = write, 0 = read).
// Reports next-level read/write traffic, miss rate in per-mille and the
// tag of the latest access; all outputs are registered (latency 1 edge).
// Optional build macro CACHE_SAT_COUNT_EN: num_reads/num_writes saturate
// at 4095 instead of wrapping.
module cache_top #(
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned NUM_SETS    = 1024,
  parameter int unsigned ASSOC       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_policy,
  input  logic              replace_policy,
  input  logic [1:0]        inclusion_policy,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic [11:0]       cache_miss_rate,
  output logic [11:0]       num_reads,
  output logic [11:0]       num_writes,
  output logic [31:0]       curr_tag
);

  localparam int unsigned OFF_W = $clog2(BLOCK_BYTES);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned WAY_W = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  typedef logic [WAY_W-1:0] way_t;

  // Per-set line state
  logic [TAG_W-1:0] r_tag   [NUM_SETS][ASSOC];
  logic [ASSOC-1:0] r_valid [NUM_SETS];
  logic [ASSOC-1:0] r_dirty [NUM_SETS];
  way_t             r_age   [NUM_SETS][ASSOC];  // 0 = most recent, ASSOC-1 = LRU
  way_t             r_fifo  [NUM_SETS];

  // Statistics
  logic [31:0] r_acc_cnt;
  logic [31:0] r_miss_cnt;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic             w_is_write;

  logic w_hit, w_inv_found;
  way_t w_hit_way, w_inv_way, w_lru_way, w_victim_way, w_fill_way, w_touch_way;
  logic w_fill, w_evict, w_evict_dirty, w_touch, w_set_dirty;

  logic [ASSOC-1:0] w_valid_set, w_dirty_set;
  way_t             w_age_set [ASSOC];
  way_t             w_fifo_set;

  logic [31:0] w_acc_d, w_miss_d;
  logic [41:0] w_prod, w_quot;
  logic [11:0] w_rate_d;
  logic        w_rd_inc, w_wr_inc;

  logic w_unused;

  assign w_tag      = cache_addr[ADDR_W-1 -: TAG_W];
  assign w_idx      = cache_addr[OFF_W +: IDX_W];
  assign w_is_write = cache_addr[0];

  // Offset bits and the multi-level policy input carry no meaning here
  assign w_unused = ^{inclusion_policy, cache_addr[OFF_W-1:1]};

  // Tag match, first free way and LRU way of the addressed set
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    w_lru_way   = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = way_t'(w);
      end
      if (!r_valid[w_idx][w] && !w_inv_found) begin
        w_inv_found = 1'b1;
        w_inv_way   = way_t'(w);
      end
      if (r_age[w_idx][w] == way_t'(ASSOC - 1)) begin
        w_lru_way = way_t'(w);
      end
    end
  end

  // Access decision: fill, eviction and recency update
  always_comb begin
    w_victim_way  = replace_policy ? r_fifo[w_idx] : w_lru_way;
    // WTNA write misses bypass the cache
    w_fill        = !w_hit && !(w_is_write && write_policy);
    w_fill_way    = w_inv_found ? w_inv_way : w_victim_way;
    w_evict       = w_fill && !w_inv_found;
    w_evict_dirty = w_evict && r_dirty[w_idx][w_victim_way];
    w_touch       = w_hit || w_fill;
    w_touch_way   = w_hit ? w_hit_way : w_fill_way;
    w_set_dirty   = w_is_write && !write_policy;
    w_rd_inc      = w_fill;
    w_wr_inc      = (w_is_write && write_policy) || w_evict_dirty;
  end

  // Next-state of the addressed set
  always_comb begin
    w_valid_set = r_valid[w_idx];
    w_dirty_set = r_dirty[w_idx];
    if (w_fill) begin
      w_valid_set[w_fill_way] = 1'b1;
      w_dirty_set[w_fill_way] = w_set_dirty;
    end else if (w_hit && w_set_dirty) begin
      w_dirty_set[w_hit_way] = 1'b1;
    end
    for (int w = 0; w < ASSOC; w++) begin
      w_age_set[w] = r_age[w_idx][w];
      if (w_touch) begin
        if (way_t'(w) == w_touch_way) begin
          w_age_set[w] = '0;
        end else if (r_age[w_idx][w] < r_age[w_idx][w_touch_way]) begin
          w_age_set[w] = r_age[w_idx][w] + way_t'(1);
        end
      end
    end
    w_fifo_set = r_fifo[w_idx];
    if (w_evict) begin
      w_fifo_set = (r_fifo[w_idx] == way_t'(ASSOC - 1)) ? '0 : r_fifo[w_idx] + way_t'(1);
    end
  end

  // Counters and miss-rate divider
  always_comb begin
    w_acc_d  = r_acc_cnt + 32'd1;
    w_miss_d = r_miss_cnt + (w_hit ? 32'd0 : 32'd1);
    w_prod   = 42'(w_miss_d) * 42'd1000;
    w_quot   = (w_acc_d == 32'd0) ? 42'd0 : w_prod / 42'(w_acc_d);
    w_rate_d = 12'(w_quot);
  end

  function automatic logic [11:0] traffic_inc(input logic [11:0] cnt, input logic en);
`ifdef CACHE_SAT_COUNT_EN
    return (en && (cnt != 12'hfff)) ? cnt + 12'd1 : cnt;
`else
    return en ? cnt + 12'd1 : cnt;
`endif
  endfunction

  // Line valid/dirty/LRU/FIFO state, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_fifo[s]  <= '0;
        for (int w = 0; w < ASSOC; w++) begin
          r_age[s][w] <= way_t'(w);
        end
      end
    end else begin
      r_valid[w_idx] <= w_valid_set;
      r_dirty[w_idx] <= w_dirty_set;
      r_fifo[w_idx]  <= w_fifo_set;
      for (int w = 0; w < ASSOC; w++) begin
        r_age[w_idx][w] <= w_age_set[w];
      end
    end
  end

  // Tag storage; contents are only meaningful under a valid bit, so no reset
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx][w_fill_way] <= w_tag;
    end
  end

  // Statistics and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_cnt       <= '0;
      r_miss_cnt      <= '0;
      cache_miss_rate <= '0;
      num_reads       <= '0;
      num_writes      <= '0;
      curr_tag        <= '0;
    end else begin
      r_acc_cnt       <= w_acc_d;
      r_miss_cnt      <= w_miss_d;
      cache_miss_rate <= w_rate_d;
      num_reads       <= traffic_inc(num_reads, w_rd_inc);
      num_writes      <= traffic_inc(num_writes, w_wr_inc);
      curr_tag        <= 32'(w_tag);
    end
  end

endmodule

// File: tb/tb_cache_top.sv
// Directed bench for cache_top: expected outputs are queued as each access
// is driven and popped for comparison after the edge that performs it.
module tb_cache_top;

  logic        clk;
  logic        reset;
  logic        write_policy;
  logic        replace_policy;
  logic [1:0]  inclusion_policy;
  logic [47:0] cache_addr;
  logic [11:0] cache_miss_rate;
  logic [11:0] num_reads;
  logic [11:0] num_writes;
  logic [31:0] curr_tag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [11:0] rd;
    logic [11:0] wr;
    logic [11:0] rate;
    logic [31:0] tag;
  } exp_t;

  exp_t sb_q[$];

  cache_top dut (
    .clk              (clk),
    .reset            (reset),
    .write_policy     (write_policy),
    .replace_policy   (replace_policy),
    .inclusion_policy (inclusion_policy),
    .cache_addr       (cache_addr),
    .cache_miss_rate  (cache_miss_rate),
    .num_reads        (num_reads),
    .num_writes       (num_writes),
    .curr_tag         (curr_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] mk_addr(input logic [31:0] tag, input logic [9:0] idx,
                                          input logic wr);
    return {tag, idx, 5'b0, wr};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  // Drive one access; when chk is set the expected result is queued and then
  // compared against the outputs 1 time unit after the performing edge.
  task automatic access(input logic [47:0] a, input bit chk, input string nm,
                        input int rd, input int wr, input int rate, input logic [31:0] tg);
    exp_t e;
    if (chk) begin
      e.name = nm;
      e.rd   = 12'(rd);
      e.wr   = 12'(wr);
      e.rate = 12'(rate);
      e.tag  = tg;
      sb_q.push_back(e);
    end
    cache_addr = a;
    @(posedge clk);
    #1;
    if (chk) begin
      if (sb_q.size() == 0) begin
        cmp({nm, "_queue"}, 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        cmp({e.name, "_reads"}, 32'(num_reads), 32'(e.rd));
        cmp({e.name, "_writes"}, 32'(num_writes), 32'(e.wr));
        cmp({e.name, "_rate"}, 32'(cache_miss_rate), 32'(e.rate));
        cmp({e.name, "_tag"}, curr_tag, e.tag);
      end
    end
  endtask

  // Pulse reset between edges and confirm the outputs clear without a clock
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b0;
    #1;
    cmp({nm, "_rst_reads"}, 32'(num_reads), 32'd0);
    cmp({nm, "_rst_writes"}, 32'(num_writes), 32'd0);
    cmp({nm, "_rst_rate"}, 32'(cache_miss_rate), 32'd0);
    cmp({nm, "_rst_tag"}, curr_tag, 32'd0);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] ta, tb, tc;
    ta = 32'h0000_0011;
    tb = 32'h0000_0022;
    tc = 32'h0000_0033;

    reset            = 1'b0;
    write_policy     = 1'b0;
    replace_policy   = 1'b0;
    inclusion_policy = 2'b10;
    cache_addr       = '0;
    #2;
    reset = 1'b1;

    // Basic WBWA / LRU trace
    do_reset("basic");
    access(48'h7fff_4938_22b0, 1, "b0", 1, 0, 1000, 32'h7fff_4938);
    access(48'h7fff_4938_22a8, 1, "b1", 1, 0, 500, 32'h7fff_4938);
    access(48'h7f30_35f6_a7c0, 1, "b2", 2, 0, 666, 32'h7f30_35f6);

    // LRU: A,B,A,C,A in one set -> C evicts B, final A hits
    do_reset("lru");
    replace_policy = 1'b0;
    access(mk_addr(ta, 10'h010, 1'b0), 1, "lru0", 1, 0, 1000, ta);
    access(mk_addr(tb, 10'h010, 1'b0), 1, "lru1", 2, 0, 1000, tb);
    access(mk_addr(ta, 10'h010, 1'b0), 1, "lru2", 2, 0, 666, ta);
    access(mk_addr(tc, 10'h010, 1'b0), 1, "lru3", 3, 0, 750, tc);
    access(mk_addr(ta, 10'h010, 1'b0), 1, "lru4", 3, 0, 600, ta);

    // FIFO: same trace -> C evicts A, final A misses
    do_reset("fifo");
    replace_policy = 1'b1;
    access(mk_addr(ta, 10'h010, 1'b0), 1, "fifo0", 1, 0, 1000, ta);
    access(mk_addr(tb, 10'h010, 1'b0), 1, "fifo1", 2, 0, 1000, tb);
    access(mk_addr(ta, 10'h010, 1'b0), 1, "fifo2", 2, 0, 666, ta);
    access(mk_addr(tc, 10'h010, 1'b0), 1, "fifo3", 3, 0, 750, tc);
    access(mk_addr(ta, 10'h010, 1'b0), 1, "fifo4", 4, 0, 800, ta);

    // WBWA write-back of a dirty victim
    do_reset("wb");
    replace_policy = 1'b0;
    write_policy   = 1'b0;
    access(mk_addr(ta, 10'h155, 1'b1), 1, "wb0", 1, 0, 1000, ta);
    access(mk_addr(tb, 10'h155, 1'b0), 1, "wb1", 2, 0, 1000, tb);
    access(mk_addr(tc, 10'h155, 1'b0), 1, "wb2", 3, 1, 1000, tc);

    // WTNA: write miss does not allocate, so the following read misses
    do_reset("wt");
    write_policy = 1'b1;
    access(mk_addr(ta, 10'h0aa, 1'b1), 1, "wt0", 0, 1, 1000, ta);
    access(mk_addr(ta, 10'h0aa, 1'b0), 1, "wt1", 1, 1, 1000, ta);

    // Mid-trace reset invalidates cached lines
    do_reset("mid");
    write_policy = 1'b0;
    access(mk_addr(tb, 10'h020, 1'b0), 1, "mid0", 1, 0, 1000, tb);
    access(mk_addr(tb, 10'h020, 1'b0), 1, "mid1", 1, 0, 500, tb);
    do_reset("mid_async");
    access(mk_addr(tb, 10'h020, 1'b0), 1, "mid2", 1, 0, 1000, tb);

    // 4100 distinct-block read misses
    do_reset("cnt");
    for (int i = 0; i < 4094; i++) begin
      access(mk_addr(32'(i + 1), 10'(i), 1'b0), 0, "", 0, 0, 0, '0);
    end
    access(mk_addr(32'd4095, 10'(4094), 1'b0), 1, "cnt4095", 4095, 0, 1000, 32'd4095);
    for (int i = 4095; i < 4099; i++) begin
      access(mk_addr(32'(i + 1), 10'(i), 1'b0), 0, "", 0, 0, 0, '0);
    end
`ifdef CACHE_SAT_COUNT_EN
    access(mk_addr(32'd4100, 10'(4099), 1'b0), 1, "cnt4100", 4095, 0, 1000, 32'd4100);
`else
    access(mk_addr(32'd4100, 10'(4099), 1'b0), 1, "cnt4100", 4, 0, 1000, 32'd4100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_top.md
Name: cache_top

Overview:
- Parameterised set-associative L1 cache model. Accepts one address per clock and tracks hit/miss state.
- Reports next-level memory traffic, miss rate (per-mille) and the tag of the current access.
- Top of the cache subsystem, used standalone for trace-driven policy evaluation.

Parameters:
ADDR_W, 48, address width.
BLOCK_BYTES, 64, line size; offset = addr[5:0].
NUM_SETS, 1024, set count; index = addr[15:6].
ASSOC, 2, ways per set.
TAG_W, ADDR_W-log2(BLOCK_BYTES)-log2(NUM_SETS) (=32), stored tag width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
write_policy  input  1  0 = write-back/write-allocate (WBWA), 1 = write-through/no-write-allocate (WTNA).
replace_policy  input  1  0 = LRU, 1 = FIFO.
inclusion_policy  input  2  reserved for multi-level builds; no effect on cache_top behaviour.
cache_addr  input  48  access address; bit 0 = access type (1 write, 0 read).
cache_miss_rate  output  12  misses*1000/accesses, integer truncated.
num_reads  output  12  next-level block reads.
num_writes  output  12  next-level writes.
curr_tag  output  32  tag of most recent access, zero-extended/truncated to 32.

Behaviour:
- reset low: all valid, dirty, LRU and FIFO state cleared, internal counters cleared, every output 0. Effect is immediate; no clock required.
- Every rising edge with reset high is exactly one access using cache_addr. Outputs are registered and show that access's effect after the same edge (latency 1 edge).
- Lookup: hit if any valid way in the set has a matching tag.
- Read hit: no traffic.
- Read miss: num_reads+1. Allocate into the lowest-index invalid way; if none, into the victim way.
- Write, WBWA:
  - Hit: set dirty.
  - Miss: num_reads+1, allocate, set dirty.
- Write, WTNA:
  - Every write: num_writes+1.
  - Miss: no allocation.
  - Dirty bit never set.
- Eviction of a dirty line: num_writes+1 (write-back), in addition to any other increment in the same access.
- LRU: per-set recency updated on every hit and fill. Victim = least recently used.
- FIFO: per-set pointer advances only on fill into a full set; hits do not change it. Victim = pointer way.
- LRU and FIFO state are both maintained at all times, so a replace_policy change takes effect on the next access.
- write_policy change mid-run: existing dirty lines stay dirty and write back on eviction.
- Internal access and miss counters are 32-bit.
- cache_miss_rate = 0 when accesses = 0; otherwise misses*1000/accesses, range 0..1000. A combinational divider feeding a register is acceptable.
- num_reads/num_writes wrap modulo 4096 unless CACHE_SAT_COUNT_EN is defined.

Optional Feature:
- CACHE_SAT_COUNT_EN defined: num_reads and num_writes saturate at 4095 and hold.
- Undefined: they wrap to 0 after 4095.
- Miss-rate computation is unaffected in both builds.

Test Plan:
- Defaults, WBWA, LRU. Reset then reads 0x7fff493822b0 (set 0x08A, tag 0x7fff4938, miss), 0x7fff493822a8 (hit), 0x7f3035f6a7c0 (set 0x29F, miss). After the third edge: num_reads=2, num_writes=0, cache_miss_rate=666, curr_tag=0x7f3035f6.
- Replacement, same set, tags A,B,A,C,A:
  - LRU: misses A,B,C; A hits twice; miss rate 600.
  - FIFO: C evicts A, so the final A misses; miss rate 800.
- WBWA write-back: write-miss A (num_reads=1), read B, read C in the same set, evicting dirty A. Expect num_reads=3, num_writes=1.
- WTNA: write-miss A, then read A. Expect num_writes=1, num_reads=1, both accesses miss, miss rate 1000.
- Assert reset low between clock edges mid-trace: all outputs read 0 before the next edge; the next access to a previously cached address misses.
- 4100 distinct-block read misses:
  - CACHE_SAT_COUNT_EN defined: num_reads=4095.
  - Undefined: num_reads=4.
  - Both builds: cache_miss_rate=1000.
